// File: rtl/matmul_mem_responder_if.sv
// rtl/matmul_mem_responder_if.sv - engine A/B/C memory ports and host register port
interface matmul_mem_responder_if;
    logic        mem_en_read_A;
    logic [9:0]  mem_addr_A;
    logic [31:0] mem_data_A;
    logic        mem_en_read_B;
    logic [9:0]  mem_addr_B;
    logic [31:0] mem_data_B;
    logic        mem_en_write_C;
    logic [9:0]  mem_addr_C;
    logic [31:0] mem_data_C;
    logic        host_req;
    logic        host_we;
    logic [9:0]  host_addr;
    logic [31:0] host_wdata;
    logic [31:0] host_rdata;
    logic        host_ack;
    logic        host_err;
    logic        result_valid;
    logic        err_sticky;

    modport slave (
        input  mem_en_read_A, mem_addr_A, mem_en_read_B, mem_addr_B,
        input  mem_en_write_C, mem_addr_C, mem_data_C,
        input  host_req, host_we, host_addr, host_wdata,
        output mem_data_A, mem_data_B, host_rdata, host_ack, host_err,
        output result_valid, err_sticky
    );

    modport master (
        output mem_en_read_A, mem_addr_A, mem_en_read_B, mem_addr_B,
        output mem_en_write_C, mem_addr_C, mem_data_C,
        output host_req, host_we, host_addr, host_wdata,
        input  mem_data_A, mem_data_B, host_rdata, host_ack, host_err,
        input  result_valid, err_sticky
    );
endinterface

// File: rtl/matmul_mem_responder.sv
// rtl/matmul_mem_responder.sv - register-backed A/B/C memory responder with host access and status
module matmul_mem_responder #(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rstn,
    matmul_mem_responder_if.slave  bus
);
    localparam int AW = $clog2(3 * DEPTH);

    // Flat storage: A at [0,DEPTH), B at [DEPTH,2*DEPTH), C at [2*DEPTH,3*DEPTH)
    logic [31:0] mem [3*DEPTH];
    logic [7:0]  c_wr_cnt;

    function automatic logic idx_ok(input logic [7:0] idx);
        return 32'(idx) < DEPTH;
    endfunction

    function automatic logic [AW-1:0] flat(input logic [9:0] a);
        return AW'(a[9:8]) * AW'(DEPTH) + AW'(a[7:0]);
    endfunction

    logic          a_ok, b_ok, c_addr_ok, c_ok;
    logic          h_stat, h_valid, h_coll, h_ok, h_mem_wr, clr, err_set;
    logic [31:0]   status_word, h_rd_word;
    logic [7:0]    cnt_base, cnt_next;
    logic [AW-1:0] h_idx, c_idx;

    always_comb begin
        a_ok      = (bus.mem_addr_A[9:8] == 2'b00) && idx_ok(bus.mem_addr_A[7:0]);
        b_ok      = (bus.mem_addr_B[9:8] == 2'b01) && idx_ok(bus.mem_addr_B[7:0]);
        c_addr_ok = (bus.mem_addr_C[9:8] == 2'b10) && idx_ok(bus.mem_addr_C[7:0]);
        c_ok      = bus.mem_en_write_C && c_addr_ok;
        c_idx     = flat(bus.mem_addr_C);
        h_idx     = flat(bus.host_addr);

        h_stat  = (bus.host_addr[9:8] == 2'b11) && (bus.host_addr[7:0] == 8'd0);
        h_valid = (bus.host_addr[9:8] == 2'b11) ? h_stat : idx_ok(bus.host_addr[7:0]);
        // The engine owns a C word it writes this cycle; a host write to it is refused
        h_coll  = bus.host_we && c_ok && (bus.host_addr[9:8] == 2'b10) && (h_idx == c_idx);
        h_ok    = bus.host_req && h_valid && !h_coll;
        h_mem_wr = h_ok && bus.host_we && !h_stat;
        clr      = h_ok && bus.host_we && h_stat && bus.host_wdata[0];

        err_set = (bus.mem_en_read_A && !a_ok) || (bus.mem_en_read_B && !b_ok) ||
                  (bus.mem_en_write_C && !c_addr_ok);

        // Clear applies before same-cycle set events
        cnt_base = clr ? 8'd0 : c_wr_cnt;
        cnt_next = (c_ok && cnt_base != 8'hFF) ? cnt_base + 8'd1 : cnt_base;

        status_word = {bus.err_sticky, bus.result_valid, 22'd0, c_wr_cnt};
        h_rd_word   = '0;
        if (h_ok && !bus.host_we)
            h_rd_word = h_stat ? status_word : mem[h_idx];
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < 3 * DEPTH; i++) mem[i] <= '0;
            c_wr_cnt         <= '0;
            bus.mem_data_A   <= '0;
            bus.mem_data_B   <= '0;
            bus.host_rdata   <= '0;
            bus.host_ack     <= 1'b0;
            bus.host_err     <= 1'b0;
            bus.result_valid <= 1'b0;
            bus.err_sticky   <= 1'b0;
        end else begin
            if (bus.mem_en_read_A)
                bus.mem_data_A <= a_ok ? mem[flat(bus.mem_addr_A)] : '0;
            if (bus.mem_en_read_B)
                bus.mem_data_B <= b_ok ? mem[flat(bus.mem_addr_B)] : '0;

            if (h_mem_wr) mem[h_idx] <= bus.host_wdata;
            if (c_ok)     mem[c_idx] <= bus.mem_data_C;

            bus.host_ack <= bus.host_req;
            bus.host_err <= bus.host_req && !h_ok;
            if (bus.host_req) bus.host_rdata <= h_rd_word;

            c_wr_cnt         <= cnt_next;
            bus.result_valid <= (bus.result_valid && !clr) || c_ok;
            bus.err_sticky   <= (bus.err_sticky && !clr) || err_set;
        end
    end
endmodule

// File: tb/tb_matmul_mem_responder.sv
// tb/tb_matmul_mem_responder.sv - table-driven and scoreboarded bench for matmul_mem_responder
module tb_matmul_mem_responder;
    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    matmul_mem_responder_if ifc ();
    matmul_mem_responder #(.DEPTH(4)) dut (.clk(clk), .rstn(rstn), .bus(ifc.slave));

    typedef struct {
        bit          we;
        bit [9:0]    addr;
        bit [31:0]   wdata;
        bit          chk;
        bit [31:0]   rd;
        bit          err;
    } hvec_t;

    typedef struct {
        bit        chk;
        bit [31:0] rd;
        bit        err;
    } exp_t;

    exp_t  sb[$];
    hvec_t tbl[$];
    int    n_vec = 0;
    int    n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic host_op(input bit we, input bit [9:0] addr, input bit [31:0] wdata,
                           input bit chk, input bit [31:0] rd, input bit err);
        exp_t e;
        ifc.host_req   = 1'b1;
        ifc.host_we    = we;
        ifc.host_addr  = addr;
        ifc.host_wdata = wdata;
        e.chk = chk; e.rd = rd; e.err = err;
        sb.push_back(e);
        tick();
        ifc.host_req = 1'b0;
        ifc.host_we  = 1'b0;
    endtask

    task automatic engine_idle();
        ifc.mem_en_read_A  = 1'b0;
        ifc.mem_en_read_B  = 1'b0;
        ifc.mem_en_write_C = 1'b0;
    endtask

    // Host ack monitor: pops one expectation per ack
    always @(negedge clk) begin
        if (rstn && ifc.host_ack) begin
            if (sb.size() == 0) begin
                check("unexpected_ack", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("host_err", {31'd0, ifc.host_err}, {31'd0, e.err});
                if (e.chk) check("host_rdata", ifc.host_rdata, e.rd);
            end
        end
    end

    initial begin
        ifc.host_req = 0; ifc.host_we = 0; ifc.host_addr = 0; ifc.host_wdata = 0;
        ifc.mem_addr_A = 0; ifc.mem_addr_B = 0; ifc.mem_addr_C = 0; ifc.mem_data_C = 0;
        engine_idle();

        // Reset state
        repeat (2) tick();
        check("rst_data_A", ifc.mem_data_A, 0);
        check("rst_data_B", ifc.mem_data_B, 0);
        check("rst_host_rdata", ifc.host_rdata, 0);
        check("rst_flags", {28'd0, ifc.host_ack, ifc.host_err, ifc.result_valid, ifc.err_sticky}, 0);
        rstn = 1'b1;
        tick();

        // Host table: preload, read back, decode boundaries, back-to-back
        tbl.push_back('{0, 10'h000, 0, 1, 32'h0000_0000, 0});
        tbl.push_back('{1, 10'h000, 32'h0403_0201, 0, 0, 0});
        tbl.push_back('{1, 10'h001, 32'h0807_0605, 0, 0, 0});
        tbl.push_back('{1, 10'h002, 32'h0C0B_0A09, 0, 0, 0});
        tbl.push_back('{1, 10'h003, 32'h100F_0E0D, 0, 0, 0});
        tbl.push_back('{1, 10'h100, 32'hB000_0000, 0, 0, 0});
        tbl.push_back('{1, 10'h101, 32'hB111_1111, 0, 0, 0});
        tbl.push_back('{1, 10'h103, 32'hB333_3333, 0, 0, 0});
        tbl.push_back('{0, 10'h001, 0, 1, 32'h0807_0605, 0});
        tbl.push_back('{0, 10'h103, 0, 1, 32'hB333_3333, 0});
        tbl.push_back('{0, 10'h004, 0, 1, 32'h0000_0000, 1});
        tbl.push_back('{1, 10'h104, 32'h1234_5678, 1, 32'h0000_0000, 1});
        tbl.push_back('{0, 10'h300, 0, 1, 32'h0000_0000, 0});
        tbl.push_back('{0, 10'h301, 0, 1, 32'h0000_0000, 1});
        tbl.push_back('{0, 10'h3FF, 0, 1, 32'h0000_0000, 1});
        tbl.push_back('{0, 10'h2FF, 0, 1, 32'h0000_0000, 1});
        foreach (tbl[i]) host_op(tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].chk, tbl[i].rd, tbl[i].err);
        tick();
        check("ack_deasserts", {31'd0, ifc.host_ack}, 0);
        check("rdata_holds", ifc.host_rdata, 0);

        // Engine reads: latency 1, then hold over idle cycles
        ifc.mem_en_read_A = 1; ifc.mem_addr_A = 10'h002;
        ifc.mem_en_read_B = 1; ifc.mem_addr_B = 10'h101;
        tick();
        engine_idle();
        check("rdA_lat1", ifc.mem_data_A, 32'h0C0B_0A09);
        check("rdB_lat1", ifc.mem_data_B, 32'hB111_1111);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("rdA_hold", ifc.mem_data_A, 32'h0C0B_0A09);
            check("rdB_hold", ifc.mem_data_B, 32'hB111_1111);
        end

        // Engine C write, then status and readback
        ifc.mem_en_write_C = 1; ifc.mem_addr_C = 10'h200; ifc.mem_data_C = 32'h0A0B_0C0D;
        tick();
        engine_idle();
        check("result_valid", {31'd0, ifc.result_valid}, 1);
        host_op(0, 10'h300, 0, 1, 32'h4000_0001, 0);
        host_op(0, 10'h200, 0, 1, 32'h0A0B_0C0D, 0);

        // Engine C write and host write to the same word: engine wins
        ifc.mem_en_write_C = 1; ifc.mem_addr_C = 10'h201; ifc.mem_data_C = 32'h1111_1111;
        host_op(1, 10'h201, 32'hFFFF_FFFF, 0, 0, 1);
        engine_idle();
        host_op(0, 10'h201, 0, 1, 32'h1111_1111, 0);

        // Engine C write and host read of the same word: host sees old data
        ifc.mem_en_write_C = 1; ifc.mem_addr_C = 10'h202; ifc.mem_data_C = 32'h2222_2222;
        host_op(0, 10'h202, 0, 1, 32'h0000_0000, 0);
        engine_idle();
        host_op(0, 10'h202, 0, 1, 32'h2222_2222, 0);
        host_op(0, 10'h300, 0, 1, 32'h4000_0003, 0);

        // Engine read and host write to the same word: engine sees old data
        ifc.mem_en_read_A = 1; ifc.mem_addr_A = 10'h000;
        host_op(1, 10'h000, 32'hDEAD_BEEF, 0, 0, 0);
        check("rd_before_wr", ifc.mem_data_A, 32'h0403_0201);
        tick();
        engine_idle();
        check("rd_after_wr", ifc.mem_data_A, 32'hDEAD_BEEF);

        // Invalid engine accesses
        ifc.mem_en_read_A = 1; ifc.mem_addr_A = 10'h104;
        tick();
        check("badA_region_data", ifc.mem_data_A, 0);
        check("badA_region_err", {31'd0, ifc.err_sticky}, 1);
        ifc.mem_addr_A = 10'h001;
        tick();
        check("rdA_idx1", ifc.mem_data_A, 32'h0807_0605);
        ifc.mem_addr_A = 10'h004;
        tick();
        engine_idle();
        check("badA_idx_data", ifc.mem_data_A, 0);
        host_op(0, 10'h305, 0, 1, 32'h0000_0000, 1);
        host_op(0, 10'h300, 0, 1, 32'hC000_0003, 0);
        host_op(1, 10'h300, 32'h0000_0000, 0, 0, 0);
        host_op(0, 10'h300, 0, 1, 32'hC000_0003, 0);
        host_op(1, 10'h300, 32'h0000_0001, 0, 0, 0);
        host_op(0, 10'h300, 0, 1, 32'h0000_0000, 0);

        // Invalid engine C write is ignored but flags an error
        ifc.mem_en_write_C = 1; ifc.mem_addr_C = 10'h000; ifc.mem_data_C = 32'h5555_5555;
        tick();
        engine_idle();
        check("badC_no_result", {30'd0, ifc.result_valid, ifc.err_sticky}, 32'd1);
        host_op(0, 10'h000, 0, 1, 32'hDEAD_BEEF, 0);

        // Status clear coincident with a valid C write: clear then set
        ifc.mem_en_write_C = 1; ifc.mem_addr_C = 10'h203; ifc.mem_data_C = 32'h3333_3333;
        host_op(1, 10'h300, 32'h0000_0001, 0, 0, 0);
        engine_idle();
        host_op(0, 10'h300, 0, 1, 32'h4000_0001, 0);

        // Counter saturation
        ifc.mem_en_write_C = 1; ifc.mem_addr_C = 10'h203;
        for (int k = 0; k < 260; k++) begin
            ifc.mem_data_C = 32'(k);
            tick();
        end
        engine_idle();
        host_op(0, 10'h300, 0, 1, 32'h4000_00FF, 0);
        host_op(0, 10'h203, 0, 1, 32'h0000_0103, 0);

        // Reset mid-access: the pending ack is aborted and memory clears
        ifc.host_req = 1; ifc.host_we = 0; ifc.host_addr = 10'h200;
        ifc.mem_en_read_A = 1; ifc.mem_addr_A = 10'h000;
        tick();
        ifc.host_req = 0;
        engine_idle();
        rstn = 1'b0;
        #1;
        check("midrst_ack", {30'd0, ifc.host_ack, ifc.host_err}, 0);
        check("midrst_data_A", ifc.mem_data_A, 0);
        check("midrst_rdata", ifc.host_rdata, 0);
        check("midrst_flags", {30'd0, ifc.result_valid, ifc.err_sticky}, 0);
        tick();
        rstn = 1'b1;
        tick();
        host_op(0, 10'h000, 0, 1, 32'h0000_0000, 0);
        host_op(0, 10'h203, 0, 1, 32'h0000_0000, 0);
        host_op(0, 10'h300, 0, 1, 32'h0000_0000, 0);
        tick();
        check("sb_drained", 32'(sb.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/matmul_mem_responder.md
# matmul_mem_responder

Memory responder serving the matrix-multiply/pooling engine's three memory ports: A read, B read and C write. It holds the A, B and C operand/result regions in on-chip registers. It answers engine reads with fixed one-cycle latency and captures engine write-backs. A host port preloads operands, reads results and accesses a status/clear register. The block sits between the engine and the system bus, as the slave end of the engine's en/addr/data memory interface.

## Interface
- DEPTH, 4: words per region (1..256); valid index = addr[7:0] < DEPTH
- clk  in  1  clock, rising edge
- rstn  in  1  reset, asynchronous, active-low
- mem_en_read_A  in  1  engine read strobe, A port
- mem_addr_A  in  10  engine read address, A port
- mem_data_A  out  32  A read data, registered
- mem_en_read_B  in  1  engine read strobe, B port
- mem_addr_B  in  10  engine read address, B port
- mem_data_B  out  32  B read data, registered
- mem_en_write_C  in  1  engine write strobe
- mem_addr_C  in  10  engine write address
- mem_data_C  in  32  engine write data
- host_req  in  1  host access request, one per cycle, no backpressure
- host_we  in  1  1 = write, 0 = read
- host_addr  in  10  host address
- host_wdata  in  32  host write data
- host_rdata  out  32  host read data, valid with host_ack
- host_ack  out  1  one-cycle pulse, exactly one cycle after each host_req
- host_err  out  1  qualifies host_ack: access was invalid or dropped
- result_valid  out  1  set by any valid engine C write
- err_sticky  out  1  set by any invalid engine access

## Operation
- Address decode, addr[9:8]:
  - 00 = A region (0x000+i)
  - 01 = B region (0x100+i)
  - 10 = C region (0x200+i)
  - 11 = status; only index 0 (0x300) is valid
- Storage: 3×DEPTH words, 32 bits each, all cleared to 0 at reset.
- Engine A port: valid only for A-region addresses. Engine B port: valid only for B-region addresses. Engine C port: valid only for C-region addresses.
- Engine read, valid address: on the strobe edge, mem_data_X <= mem[addr].
- Engine read, invalid address: mem_data_X <= 0 and err_sticky set.
- Engine read data holds its value until the next strobe on that port. There is no idle clearing.
- Engine write, valid address: mem[C idx] <= mem_data_C, result_valid <= 1, c_wr_cnt incremented.
- Engine write, invalid address: the write is ignored and err_sticky is set.
- c_wr_cnt is an internal 8-bit counter that saturates at 255.
- Host access may target any region. Host read of 0x300 returns:
  - bit 31 = err_sticky
  - bit 30 = result_valid
  - bits 7:0 = c_wr_cnt
  - all other bits = 0
- Host write to 0x300 with wdata[0] = 1 clears err_sticky, result_valid and c_wr_cnt. With wdata[0] = 0 the write has no effect.
- Host access to any invalid address: ack with host_err = 1, host_rdata = 0, no state change.
- Collisions within one cycle:
  - Engine read and host write to the same word: the engine gets the old data (read-before-write).
  - Engine C write and host write to the same C word: the engine write wins; the host write is dropped and acked with host_err = 1.
  - Engine C write and host read of the same word: the host gets the old data.
  - Status clear together with a set event (engine write or error): clear first, then set. For example, clear plus a valid C write gives result_valid = 1, c_wr_cnt = 1.
- A, B and C port activity may all occur in the same cycle, independently.

## Timing
- Engine reads: latency 1. Strobe high at edge N means data is valid after edge N and is stable through edge N+1 and beyond.
- Engine writes take effect at the strobe edge. A read of the same word issued one cycle later returns the new data.
- Host: request sampled at edge N; host_ack, host_rdata and host_err are driven after edge N and deasserted after edge N+1 unless another request was made.
- Host requests may be back-to-back, one ack per request, in order.
- host_rdata holds its value between acks.
- Reset: every output is 0 (mem_data_A, mem_data_B, host_rdata, host_ack, host_err, result_valid, err_sticky), c_wr_cnt = 0, memory is 0.
- Reset asserted mid-access aborts the access: no ack is produced and pending writes are lost.

## Test plan
- Reset, then host read 0x000 → ack one cycle later with rdata = 0x00000000 and err = 0; all outputs are 0 during reset.
- Host writes A[0..3] = 0x04030201, 0x08070605, 0x0C0B0A09, 0x100F0E0D; engine strobes A at 0x002 → mem_data_A = 0x0C0B0A09 the next cycle and holds for 3 idle cycles. Same check on B at 0x101.
- Engine writes 0x200 with 0x0A0B0C0D → result_valid = 1; host read 0x300 → 0x40000001; host read 0x200 → 0x0A0B0C0D.
- Same cycle: engine writes 0x201 with 0x11111111 and host writes 0x201 with 0xFFFFFFFF → host ack with err = 1; a subsequent read returns 0x11111111.
- Engine A strobe at 0x104 and at 0x004 (DEPTH = 4) → mem_data_A = 0 and err_sticky = 1. Host read 0x305 → ack with err = 1. Host write 0x300 with 0x1 → status reads 0x00000000.
- Host status clear in the same cycle as a valid engine C write → status reads 0x40000001. Asserting rstn low mid-sequence → all outputs and memory are 0 immediately.
